// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed multi-digit 7-segment driver: BCD decode, leading-zero blanking,
// frame-synchronous display update and selectable segment/anode polarity.
module seven_seg_mux_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_LEADING  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            code,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIVW = $clog2(REFRESH_DIV);
  localparam int unsigned NUMW = 4 * DIGITS;

  localparam logic [6:0]        SEG_ZERO = 7'b1111110;
  localparam logic [6:0]        SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_POL   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_POL   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b1000111;
    endcase
  endfunction

  logic [DIVW-1:0]   div_cnt;
  logic [IDXW-1:0]   idx;
  logic [NUMW-1:0]   disp_num, pend_num;
  logic [DIGITS-1:0] disp_dp, pend_dp;
  logic              pend_valid;

  logic              step, wrap;
  logic [IDXW-1:0]   idx_nx;
  logic [NUMW-1:0]   disp_num_nx;
  logic [DIGITS-1:0] disp_dp_nx;
  logic [3:0]        nib_sel;
  logic              dp_sel, blank_sel, zero_run;
  logic [6:0]        seg_nx;
  logic [DIGITS-1:0] an_nx;

  // Scan advance and frame-boundary display swap
  always_comb begin
    step        = (div_cnt == DIVW'(REFRESH_DIV - 1));
    wrap        = step && (idx == IDXW'(DIGITS - 1));
    idx_nx      = idx;
    disp_num_nx = disp_num;
    disp_dp_nx  = disp_dp;
    if (step) idx_nx = wrap ? '0 : idx + IDXW'(1);
    if (wrap && pend_valid) begin
      disp_num_nx = pend_num;
      disp_dp_nx  = pend_dp;
    end
  end

  // Select the digit about to be shown; zero_run tracks all-zero nibbles from the top down
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    zero_run  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_num_nx[4*i +: 4] == 4'd0);
      if (IDXW'(i) == idx_nx) begin
        nib_sel   = disp_num_nx[4*i +: 4];
        dp_sel    = disp_dp_nx[i];
        blank_sel = zero_run && (i != 0);
      end
    end
    seg_nx = ((BLANK_LEADING != 0) && blank_sel) ? 7'b0000000 : decode(nib_sel);
    an_nx  = DIGITS'(1) << idx_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      idx        <= '0;
      disp_num   <= '0;
      disp_dp    <= '0;
      pend_num   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      code       <= SEG_ZERO ^ SEG_POL;
      dp         <= DP_POL;
      anode      <= DIGITS'(1) ^ AN_POL;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= step ? '0 : div_cnt + DIVW'(1);
      idx        <= idx_nx;
      disp_num   <= disp_num_nx;
      disp_dp    <= disp_dp_nx;
      frame_tick <= wrap;
      // A load coinciding with a wrap stays pending for the following frame
      if (load) begin
        pend_num   <= number;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
      if (step) begin
        code  <= seg_nx ^ SEG_POL;
        dp    <= dp_sel ^ DP_POL;
        anode <= an_nx ^ AN_POL;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver: three instances (blanking, no blanking,
// inverted polarity) checked against a queue of expected frames.
module tb_seven_seg_mux_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] number;
  logic [3:0]  dp_in;

  logic [6:0] code_b, code_n, code_i;
  logic       dp_b, dp_n, dp_i;
  logic [3:0] anode_b, anode_n, anode_i;
  logic       ft_b, ft_n, ft_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] SF = 7'b1000111;
  localparam logic [6:0] BL = 7'b0000000;

  typedef struct packed {
    logic [27:0] c;   // {d3,d2,d1,d0} codes with leading blanking
    logic [27:0] n;   // same without blanking
    logic [3:0]  d;
  } frame_t;

  frame_t sb[$];

  always #5 clk = ~clk;

  seven_seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1),
                         .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .number(number), .dp_in(dp_in), .load(load),
    .code(code_b), .dp(dp_b), .anode(anode_b), .frame_tick(ft_b));

  seven_seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(0),
                         .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_n (
    .clk(clk), .reset(reset), .number(number), .dp_in(dp_in), .load(load),
    .code(code_n), .dp(dp_n), .anode(anode_n), .frame_tick(ft_n));

  seven_seg_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_i (
    .clk(clk), .reset(reset), .number(number), .dp_in(dp_in), .load(load),
    .code(code_i), .dp(dp_i), .anode(anode_i), .frame_tick(ft_i));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] n, input logic [3:0] d);
    number = n;
    dp_in  = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic push_frame(input logic [27:0] c, input logic [27:0] n, input logic [3:0] d);
    frame_t f;
    f.c = c;
    f.n = n;
    f.d = d;
    sb.push_back(f);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (ft_b !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " frame_timeout"}, 32'(n < 100), 32'd1);
  endtask

  // Walk one full frame starting at the wrap sample, comparing every cycle
  task automatic check_frame(input string tag);
    frame_t     f;
    logic [6:0] ec, en, eci;
    logic [3:0] ea, eai;
    logic       ed, edi;
    chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    f = sb.pop_front();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        ec  = f.c[7*d +: 7];
        en  = f.n[7*d +: 7];
        eci = ~ec;
        ea  = 4'(1 << d);
        eai = ~ea;
        ed  = f.d[d];
        edi = ~ed;
        chk($sformatf("%s d%0d c%0d anode", tag, d, c), 32'(anode_b), 32'(ea));
        chk($sformatf("%s d%0d c%0d code", tag, d, c), 32'(code_b), 32'(ec));
        chk($sformatf("%s d%0d c%0d dp", tag, d, c), 32'(dp_b), 32'(ed));
        chk($sformatf("%s d%0d c%0d tick", tag, d, c), 32'(ft_b), 32'(d == 0 && c == 0));
        chk($sformatf("%s d%0d c%0d code_nb", tag, d, c), 32'(code_n), 32'(en));
        chk($sformatf("%s d%0d c%0d dp_nb", tag, d, c), 32'(dp_n), 32'(ed));
        chk($sformatf("%s d%0d c%0d anode_nb", tag, d, c), 32'(anode_n), 32'(ea));
        chk($sformatf("%s d%0d c%0d code_inv", tag, d, c), 32'(code_i), 32'(eci));
        chk($sformatf("%s d%0d c%0d anode_inv", tag, d, c), 32'(anode_i), 32'(eai));
        chk($sformatf("%s d%0d c%0d dp_inv", tag, d, c), 32'(dp_i), 32'(edi));
        chk($sformatf("%s d%0d c%0d tick_inv", tag, d, c), 32'(ft_i), 32'(ft_b));
        tick();
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    number = '0;
    dp_in  = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst anode", 32'(anode_b), 32'h1);
    chk("rst code", 32'(code_b), 32'(S0));
    chk("rst dp", 32'(dp_b), 32'h0);
    chk("rst tick", 32'(ft_b), 32'h0);
    chk("rst anode_inv", 32'(anode_i), 32'hE);
    chk("rst code_inv", 32'(code_i), 32'h01);
    chk("rst dp_inv", 32'(dp_i), 32'h1);

    // First step edge four cycles after release
    repeat (3) tick();
    chk("pre-step anode", 32'(anode_b), 32'h1);
    tick();
    chk("step1 anode", 32'(anode_b), 32'h2);
    chk("step1 code blank", 32'(code_b), 32'(BL));
    chk("step1 code_nb", 32'(code_n), 32'(S0));
    chk("step1 code_inv", 32'(code_i), 32'h7F);

    // Mid-frame load must not disturb the current frame
    do_load(16'h1234, 4'b0100);
    push_frame({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b0100);
    chk("midload anode", 32'(anode_b), 32'h2);
    chk("midload code", 32'(code_b), 32'(BL));
    wait_frame("f1234");
    check_frame("f1234");

    // Leading-zero blanking, dp still shown on a blanked digit
    do_load(16'h0070, 4'b1000);
    push_frame({BL, BL, S7, S0}, {S0, S0, S7, S0}, 4'b1000);
    wait_frame("f0070");
    check_frame("f0070");

    do_load(16'h00A5, 4'b0000);
    push_frame({BL, BL, SF, S5}, {S0, S0, SF, S5}, 4'b0000);
    wait_frame("f00A5");
    check_frame("f00A5");

    do_load(16'h0000, 4'b0000);
    push_frame({BL, BL, BL, S0}, {S0, S0, S0, S0}, 4'b0000);
    wait_frame("f0000");
    check_frame("f0000");

    // Load exactly on the wrap edge while 2222 is pending
    do_load(16'h2222, 4'b1001);
    push_frame({S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b1001);
    repeat (14) tick();
    chk("prewrap tick", 32'(ft_b), 32'h0);
    do_load(16'h1111, 4'b0000);
    push_frame({S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'b0000);
    wait_frame("f2222");
    check_frame("f2222");
    wait_frame("f1111");
    check_frame("f1111");

    // Two loads in one frame: last one wins
    do_load(16'h3333, 4'b0001);
    repeat (3) tick();
    do_load(16'h4444, 4'b0010);
    push_frame({S4, S4, S4, S4}, {S4, S4, S4, S4}, 4'b0010);
    wait_frame("f4444");
    check_frame("f4444");

    // Reset mid-scan at idx 2 with data pending
    do_load(16'h5555, 4'b1111);
    repeat (7) tick();
    chk("idx2 anode", 32'(anode_b), 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst anode", 32'(anode_b), 32'h1);
    chk("midrst code", 32'(code_b), 32'(S0));
    chk("midrst dp", 32'(dp_b), 32'h0);
    chk("midrst tick", 32'(ft_b), 32'h0);
    chk("midrst anode_inv", 32'(anode_i), 32'hE);
    chk("midrst code_inv", 32'(code_i), 32'h01);
    push_frame({BL, BL, BL, S0}, {S0, S0, S0, S0}, 4'b0000);
    wait_frame("fpostrst");
    check_frame("fpostrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
